// File: rtl/adc_calib_avg.sv
// Offset/gain calibration of decimated sinc3 samples, then a power-of-two block averager.
// Latency: calibrated sample 3 clocks after in_valid; averaged result 1 clock after the window's last sample.
// Backpressure: none upstream; a result arriving while out_data is unconsumed is dropped and flagged in overrun.
module adc_calib_avg #(
    parameter int IN_WIDTH    = 25,
    parameter int OUT_WIDTH   = 16,
    parameter int AVG_LOG_MAX = 4
) (
    input  logic                        clock,
    input  logic                        aclr,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  offset,
    input  logic [17:0]                 gain,
    input  logic [2:0]                  avg_log,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun,
    output logic                        sat,
    input  logic                        clr_flags
);

    localparam int DW = IN_WIDTH + 1;
    localparam int PW = IN_WIDTH + 19;
    localparam int S  = 16 + IN_WIDTH - OUT_WIDTH;
    localparam int AW = OUT_WIDTH + AVG_LOG_MAX;
    localparam int CW = AVG_LOG_MAX + 1;

    // One extra bit on the rounding path so adding the half-LSB never wraps.
    localparam logic signed [PW:0] RND  = (PW+1)'(1) << (S - 1);
    localparam logic signed [PW:0] CMAX = (PW+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [PW:0] CMIN = (PW+1)'(-(2**(OUT_WIDTH-1)));

    logic signed [DW-1:0]        diff_q, diff_d;
    logic [17:0]                 gain_q, gain_d;
    logic                        s1_vld_q, s1_vld_d;
    logic signed [PW-1:0]        prod_q, prod_d;
    logic                        s2_vld_q, s2_vld_d;
    logic signed [OUT_WIDTH-1:0] cal_q, cal_d;
    logic                        cal_vld_q, cal_vld_d;
    logic                        sat_q, sat_d;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [2:0]                  l_q, l_d;
    logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_vld_q, out_vld_d;
    logic                        overrun_q, overrun_d;

    logic signed [PW:0]          rnd_sum, cal_shift;
    logic                        sat_set;
    logic signed [AW-1:0]        acc_sum;
    logic signed [AW:0]          half, avg_rnd, avg_shift;
    logic [2:0]                  l_new, l_eff;
    logic [CW-1:0]               cnt_inc;
    logic                        last, new_res;
    logic signed [OUT_WIDTH-1:0] result;

    // Stages 1-2: offset subtraction with gain captured alongside, then exact signed multiply.
    always_comb begin
        diff_d   = diff_q;
        gain_d   = gain_q;
        s1_vld_d = in_valid;
        if (in_valid) begin
            diff_d = DW'(in_data) - DW'(offset);
            gain_d = gain;
        end
        prod_d   = PW'(diff_q) * PW'($signed({1'b0, gain_q}));
        s2_vld_d = s1_vld_q;
    end

    // Stage 3: round half up back to output scale, clamp, and flag saturation.
    always_comb begin
        rnd_sum   = (PW+1)'(prod_q) + RND;
        cal_shift = rnd_sum >>> S;
        sat_set   = 1'b0;
        cal_d     = cal_shift[OUT_WIDTH-1:0];
        if (cal_shift > CMAX) begin
            cal_d   = CMAX[OUT_WIDTH-1:0];
            sat_set = s2_vld_q;
        end else if (cal_shift < CMIN) begin
            cal_d   = CMIN[OUT_WIDTH-1:0];
            sat_set = s2_vld_q;
        end
        cal_vld_d = s2_vld_q;
        sat_d     = sat_set ? 1'b1 : (clr_flags ? 1'b0 : sat_q);
    end

    // Averager: window length is frozen on the window's first sample; result rounds half up.
    always_comb begin
        l_new     = (avg_log > 3'(AVG_LOG_MAX)) ? 3'(AVG_LOG_MAX) : avg_log;
        l_eff     = (cnt_q == '0) ? l_new : l_q;
        acc_sum   = acc_q + AW'(cal_q);
        cnt_inc   = cnt_q + CW'(1);
        last      = (cnt_inc == (CW'(1) << l_eff));
        half      = ((AW+1)'(1) << l_eff) >> 1;
        avg_rnd   = (AW+1)'(acc_sum) + half;
        avg_shift = avg_rnd >>> l_eff;
        result    = avg_shift[OUT_WIDTH-1:0];
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        l_d       = l_q;
        new_res   = 1'b0;
        if (cal_vld_q) begin
            l_d = l_eff;
            if (last) begin
                acc_d   = '0;
                cnt_d   = '0;
                new_res = 1'b1;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    // Output register: load when free or draining this cycle, otherwise drop and flag overrun.
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        overrun_d  = clr_flags ? 1'b0 : overrun_q;
        if (new_res) begin
            if (!out_vld_q || out_ready) begin
                out_data_d = result;
                out_vld_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_vld_q && out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // All state, cleared asynchronously so a reset mid-window discards everything in flight.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            diff_q     <= '0;
            gain_q     <= '0;
            s1_vld_q   <= 1'b0;
            prod_q     <= '0;
            s2_vld_q   <= 1'b0;
            cal_q      <= '0;
            cal_vld_q  <= 1'b0;
            sat_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            l_q        <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            diff_q     <= diff_d;
            gain_q     <= gain_d;
            s1_vld_q   <= s1_vld_d;
            prod_q     <= prod_d;
            s2_vld_q   <= s2_vld_d;
            cal_q      <= cal_d;
            cal_vld_q  <= cal_vld_d;
            sat_q      <= sat_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            l_q        <= l_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_vld_q;
    assign overrun   = overrun_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_adc_calib_avg.sv
// Directed bench for adc_calib_avg with default parameters (S = 25).
// Results are captured on every out_valid/out_ready transfer and compared in order.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_adc_calib_avg;

    logic               clock;
    logic               aclr;
    logic signed [24:0] in_data;
    logic               in_valid;
    logic signed [24:0] offset;
    logic [17:0]        gain;
    logic [2:0]         avg_log;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;
    logic               sat;
    logic               clr_flags;

    int n_checks = 0;
    int n_errors = 0;
    int res_q[$];

    adc_calib_avg #(.IN_WIDTH(25), .OUT_WIDTH(16), .AVG_LOG_MAX(4)) dut (
        .clock     (clock),
        .aclr      (aclr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .offset    (offset),
        .gain      (gain),
        .avg_log   (avg_log),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .sat       (sat),
        .clr_flags (clr_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record each value that transfers on the next rising edge.
    always @(negedge clock) begin
        if (!aclr && out_valid && out_ready) res_q.push_back(int'(out_data));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input int v);
        in_data  = 25'(v);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int exp);
        check({tag, "_count"}, res_q.size(), 1);
        if (res_q.size() > 0) check(tag, res_q.pop_front(), exp);
        res_q.delete();
    endtask

    task automatic pulse_clr;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    initial begin
        aclr = 1'b1; in_data = '0; in_valid = 1'b0; offset = '0; gain = 18'd65536;
        avg_log = 3'd0; out_ready = 1'b1; clr_flags = 1'b0;
        tick(3);
        @(negedge clock);
        check("rst_out_data",  int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_overrun",   int'(overrun), 0);
        check("rst_sat",       int'(sat), 0);
        @(posedge clock); #1;
        aclr = 1'b0;
        tick(2);

        // Unity gain, L=0: exact latency of 4 clocks.
        send(512);
        tick(2);
        @(negedge clock);
        check("lat3_valid", int'(out_valid), 0);
        @(negedge clock);
        check("lat4_valid", int'(out_valid), 1);
        check("lat4_data",  int'(out_data), 1);
        tick(3);
        check("valid_drops", int'(out_valid), 0);
        expect_result("pulse_512", 1);
        send(-512);  tick(6); expect_result("pulse_m512", -1);
        send(256);   tick(6); expect_result("half_up_pos", 1);
        send(-256);  tick(6); expect_result("half_up_neg", 0);

        // Gain captured per sample: back-to-back samples with different gains.
        in_data = 25'sd512; in_valid = 1'b1; gain = 18'd65536;
        tick(1);
        gain = 18'd131072;
        tick(1);
        in_valid = 1'b0; gain = 18'd65536;
        tick(6);
        check("gain_seq_count", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check("gain_seq_0", res_q[0], 1);
            check("gain_seq_1", res_q[1], 2);
        end
        res_q.delete();

        // Saturation high and low, sticky until cleared.
        gain = 18'd131072;
        send(16777215); tick(6);
        expect_result("sat_hi", 32767);
        check("sat_hi_flag", int'(sat), 1);
        pulse_clr;
        check("sat_clr", int'(sat), 0);
        send(-16777216); tick(6);
        expect_result("sat_lo", -32768);
        check("sat_lo_flag", int'(sat), 1);
        pulse_clr;
        check("sat_clr2", int'(sat), 0);

        // Offset plus averaging over 4: calibrated 1,1,2,2 -> 2.
        gain = 18'd65536; offset = 25'sd1024; avg_log = 3'd2;
        send(1536); send(1536); send(2048); send(2048);
        tick(6);
        expect_result("avg4", 2);

        // Length change mid-window is ignored.
        send(1536); tick(5);
        avg_log = 3'd0;
        send(1536); send(2048); send(2048);
        tick(6);
        expect_result("avg4_midchg", 2);

        // Negative average rounds half up: (-1 + -2)/2 -> -1.
        offset = '0; avg_log = 3'd1;
        send(-512); send(-1024);
        tick(6);
        expect_result("avg2_neg", -1);

        // Backpressure: second result dropped, first held.
        avg_log = 3'd0; out_ready = 1'b0;
        send(512); send(1024);
        tick(6);
        check("bp_valid",   int'(out_valid), 1);
        check("bp_data",    int'(out_data), 1);
        check("bp_overrun", int'(overrun), 1);
        out_ready = 1'b1;
        tick(1);
        check("bp_drained", int'(out_valid), 0);
        expect_result("bp_xfer", 1);
        pulse_clr;
        check("ovr_clr", int'(overrun), 0);

        // avg_log beyond the maximum clamps to 16 samples.
        avg_log = 3'd7;
        for (int i = 0; i < 15; i++) send(512);
        tick(6);
        check("len16_early", res_q.size(), 0);
        send(512); tick(6);
        expect_result("len16", 1);

        // Reset mid-window discards the partial sum.
        gain = 18'd131072;
        send(16777215); tick(6); res_q.delete();
        gain = 18'd65536;
        for (int i = 0; i < 5; i++) send(512);
        tick(2);
        aclr = 1'b1;
        #1;
        check("arst_data",    int'(out_data), 0);
        check("arst_valid",   int'(out_valid), 0);
        check("arst_overrun", int'(overrun), 0);
        check("arst_sat",     int'(sat), 0);
        tick(2);
        aclr = 1'b0;
        tick(1);
        res_q.delete();
        for (int i = 0; i < 15; i++) send(512);
        tick(6);
        check("post_rst_early", res_q.size(), 0);
        send(512); tick(6);
        expect_result("post_rst_len16", 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_calib_avg.md
ADC_CALIB_AVG -- requirements
Module: adc_calib_avg

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 25, signed width of incoming decimated sinc3 sample.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, signed width of calibrated output sample.
REQ-003 SHALL have parameter AVG_LOG_MAX, default 4, maximum log2 of averaging length.
REQ-004 SHALL have clock  input  1  rising-edge clock, same domain as upstream sinc3 decimator.
REQ-005 SHALL have aclr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have in_data  input  IN_WIDTH  signed decimated sample.
REQ-007 SHALL have in_valid  input  1  one-cycle qualifier for in_data; back-to-back allowed.
REQ-008 SHALL have offset  input  IN_WIDTH  signed offset subtracted from in_data.
REQ-009 SHALL have gain  input  18  unsigned UQ2.16 gain; 65536 = 1.0.
REQ-010 SHALL have avg_log  input  3  log2 of averaging length N.
REQ-011 SHALL have out_data  output  OUT_WIDTH  signed averaged calibrated sample.
REQ-012 SHALL have out_valid  output  1  out_data holds an unconsumed result.
REQ-013 SHALL have out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-014 SHALL have overrun  output  1  sticky: a result was dropped.
REQ-015 SHALL have sat  output  1  sticky: a calibrated sample saturated.
REQ-016 SHALL have clr_flags  input  1  synchronous clear of overrun and sat.

Function
REQ-017 Stage 1 (on in_valid): diff = in_data - offset, IN_WIDTH+1 bits, exact.
REQ-018 Stage 2: prod = diff * gain, signed, full width (IN_WIDTH+19 bits), exact.
REQ-019 Stage 3: cal = (prod + 2^(S-1)) >>> S, S = 16 + IN_WIDTH - OUT_WIDTH (round half up); clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; clamp sets sat.
REQ-020 Calibrated sample SHALL be available exactly 3 clocks after in_valid; pipeline fully pipelined, one sample/clock.
REQ-021 Averager: accumulator OUT_WIDTH+AVG_LOG_MAX bits signed, counter AVG_LOG_MAX+1 bits.
REQ-022 Effective length L = min(avg_log, AVG_LOG_MAX), latched when window counter is 0 (first sample of a window); changes mid-window ignored until next window.
REQ-023 On 2^L-th sample: result = (acc_total + 2^(L-1)) >>> L for L>0, result = cal for L=0; accumulator and counter restart at 0 same cycle.
REQ-024 Result SHALL be presented 1 clock after its last calibrated sample: L=0 gives in_valid -> out_valid latency 4 clocks.
REQ-025 Output handshake: transfer when out_valid & out_ready; out_data stable while out_valid & !out_ready.
REQ-026 New result with out_valid=0, or with out_valid & out_ready same cycle: load result, out_valid=1.
REQ-027 New result with out_valid & !out_ready: result discarded, out_data unchanged, overrun=1.
REQ-028 Transfer with no new result: out_valid=0 next cycle.
REQ-029 clr_flags coincident with a new set event: set wins.
REQ-030 offset, gain sampled on the in_valid cycle of each sample; changes affect only later samples.

Reset
REQ-031 aclr SHALL asynchronously clear all pipeline registers, accumulator, window counter, latched L, out_data=0, out_valid=0, overrun=0, sat=0.
REQ-032 aclr mid-window SHALL discard partial sum; first sample after release starts a new window; samples in flight are lost.

Verification (IN_WIDTH=25, OUT_WIDTH=16, S=25)
REQ-033 gain=65536, offset=0, avg_log=0, in_data=512 pulse -> out_data=1, out_valid 4 clocks later; in_data=-512 -> out_data=-1.
REQ-034 gain=131072, offset=0, in_data=16777215 -> out_data=32767, sat=1; clr_flags -> sat=0.
REQ-035 gain=65536, offset=1024, avg_log=2, in_data 1536,1536,2048,2048 back-to-back -> single result out_data=2 (sum 6, rounded /4).
REQ-036 out_ready=0, avg_log=0, in_data 512 then 1024 -> out_data stays 1, overrun=1; out_ready=1 -> transfer, out_valid=0.
REQ-037 avg_log=7 -> behaves as L=4: 16 samples of 512 -> out_data=1; aclr after 5 samples -> all outputs 0, next 16 samples give one result.
